// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and widths for the instruction-fetch stage.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int LUT_IDX_W = 5;
    localparam int INSTR_W   = 9;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
// Module      : branch_lut
// Description : Branch target table; one synchronous write port and one
//               asynchronous read port (a same-cycle write is not forwarded).
// Revision    : 1.0  initial release
// ============================================================================
module branch_lut #(
    parameter int DEPTH = 32,
    parameter int PC_W  = 10,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [PC_W-1:0]  i_wr_data,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [PC_W-1:0]  o_rd_data
);

    logic [PC_W-1:0] r_mem [DEPTH];

    // Contents deliberately have no reset: the table survives a fetch reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Program counter, ROM addressing and branch resolution for one
//               program run (start pulse to done). Optional counters are
//               enabled with the FETCH_PERF_EN macro.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_W-1:0]      end_pc,
    input  logic                 branch_en,
    input  logic [LUT_IDX_W-1:0] lut_index,
    input  logic                 lut_wr_en,
    input  logic [LUT_IDX_W-1:0] lut_wr_addr,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    output logic [PC_W-1:0]      pc,
    output logic                 done
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]     instr_count,
    output logic [CNT_W-1:0]     taken_count
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_lut_target;
    logic [PC_W-1:0] w_addr;
    logic            r_done;
    logic            w_done_next;
    logic            w_valid;
    logic            w_at_end;
    logic            w_start_accept;

    branch_lut #(
        .DEPTH (LUT_DEPTH),
        .PC_W  (PC_W),
        .IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .clk       (clk),
        .i_wr_en   (lut_wr_en),
        .i_wr_addr (lut_wr_addr),
        .i_wr_data (lut_wr_data),
        .i_rd_addr (lut_index),
        .o_rd_data (w_lut_target)
    );

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_at_end = (r_pc == end_pc);

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_done_next    = r_done;
        w_valid        = 1'b0;
        w_addr         = '0;
        w_start_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = FILL;
                    w_pc_next      = '0;
                    w_start_accept = 1'b1;
                end
            end
            FILL: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (w_at_end) begin
                    // The word at end_pc is fetched but never issued.
                    w_state_next = HALT;
                    w_done_next  = 1'b1;
                    w_addr       = r_pc;
                end else begin
                    w_valid   = 1'b1;
                    w_pc_next = branch_en ? w_lut_target : w_pc_inc;
                    w_addr    = w_pc_next;
                end
            end
            HALT: begin
                if (start) begin
                    w_state_next   = FILL;
                    w_pc_next      = '0;
                    w_done_next    = 1'b0;
                    w_start_accept = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_pc_next    = '0;
                w_done_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_done  <= w_done_next;
        end
    end

    assign imem_addr   = w_addr;
    assign instr       = imem_data;
    assign instr_valid = w_valid;
    assign pc          = r_pc;
    assign done        = r_done;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_taken_count;

    always_ff @(posedge clk) begin
        if (reset || w_start_accept) begin
            r_instr_count <= '0;
            r_taken_count <= '0;
        end else begin
            r_instr_count <= sat_inc(r_instr_count, w_valid);
            r_taken_count <= sat_inc(r_taken_count, w_valid && branch_en);
        end
    end

    assign instr_count = r_instr_count;
    assign taken_count = r_taken_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed vector table,
//               hand sequences and randomized run against a reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int NPC   = 1 << PC_W;
    localparam int P_IDLE = 0, P_FILL = 1, P_RUN = 2, P_HALT = 3;

    logic            clk = 1'b0;
    logic            reset, start, branch_en, lut_wr_en;
    logic [PC_W-1:0] end_pc, lut_wr_data, imem_addr, pc;
    logic [4:0]      lut_index, lut_wr_addr;
    logic [8:0]      imem_data, instr;
    logic            instr_valid, done;
`ifdef FETCH_PERF_EN
    logic [15:0]     instr_count, taken_count;
`endif

    fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .end_pc      (end_pc),
        .branch_en   (branch_en),
        .lut_index   (lut_index),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .done        (done)
`ifdef FETCH_PERF_EN
        ,
        .instr_count (instr_count),
        .taken_count (taken_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM with one cycle of read latency.
    logic [8:0] rom [NPC];
    always @(posedge clk) imem_data <= rom[imem_addr];

    int total = 0;
    int bad   = 0;

    // Reference model: program phase, pc, done flag, counters, target table.
    int m_phase, m_pc, m_done, m_ic, m_tc, m_prev_addr;
    bit m_rom_ok = 1'b0;
    int m_lut [32];
    int e_valid, e_addr;

    typedef struct {
        bit st; int endp; bit br; int idx;
        int ev; int epc; int eaddr; int edone;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_valid = 0;
        e_addr  = 0;
        if (m_phase == P_RUN) begin
            if (m_pc == int'(end_pc)) begin
                e_addr = m_pc;
            end else begin
                e_valid = 1;
                e_addr  = branch_en ? m_lut[lut_index] : (m_pc + 1) % NPC;
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (reset) begin
            m_phase = P_IDLE; m_pc = 0; m_done = 0; m_ic = 0; m_tc = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin m_phase = P_FILL; m_pc = 0; m_ic = 0; m_tc = 0; end
                P_FILL: m_phase = P_RUN;
                P_RUN: begin
                    if (e_valid == 0) begin
                        m_phase = P_HALT; m_done = 1;
                    end else begin
                        m_ic = (m_ic < 65535) ? m_ic + 1 : m_ic;
                        if (branch_en) m_tc = (m_tc < 65535) ? m_tc + 1 : m_tc;
                        m_pc = e_addr;
                    end
                end
                default: if (start) begin
                    m_phase = P_FILL; m_pc = 0; m_done = 0; m_ic = 0; m_tc = 0;
                end
            endcase
        end
        if (lut_wr_en) m_lut[lut_wr_addr] = int'(lut_wr_data);
        m_prev_addr = e_addr;
        m_rom_ok    = 1'b1;
        #2;
    endtask

    task automatic check_model();
        model_eval();
        chk("m_valid", {31'b0, instr_valid}, e_valid);
        chk("m_pc", {22'b0, pc}, m_pc);
        chk("m_addr", {22'b0, imem_addr}, e_addr);
        chk("m_done", {31'b0, done}, m_done);
        if (m_rom_ok) chk("m_instr", {23'b0, instr}, {23'b0, rom[m_prev_addr]});
`ifdef FETCH_PERF_EN
        chk("m_icnt", {16'b0, instr_count}, m_ic);
        chk("m_tcnt", {16'b0, taken_count}, m_tc);
`endif
    endtask

    task automatic add(input bit st, input int endp, input bit br, input int idx,
                       input int ev, input int epc, input int eaddr, input int edone);
        vec_t v;
        v = '{st, endp, br, idx, ev, epc, eaddr, edone};
        tv.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < NPC; i++) rom[i] = 9'($urandom);
        reset = 1'b1; start = 1'b0; end_pc = '0; branch_en = 1'b0; lut_index = '0;
        lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
        m_phase = P_IDLE; m_pc = 0; m_done = 0; m_ic = 0; m_tc = 0; m_prev_addr = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_pc", {22'b0, pc}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_addr", {22'b0, imem_addr}, 0);

        // Load the target table while idle.
        lut_wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            lut_wr_addr = 5'(i);
            lut_wr_data = (i == 3) ? 10'd20 : (i == 10) ? 10'd3 : (i == 11) ? 10'd6 :
                          (i == 12) ? 10'd9 : PC_W'(i);
            tick();
        end
        lut_wr_en = 1'b0;

        // st endp br idx | valid pc addr done
        add(1, 4, 0, 0, 0, 0, 0, 0);
        add(0, 4, 0, 0, 0, 0, 0, 0);
        add(0, 4, 0, 0, 1, 0, 1, 0);
        add(0, 4, 0, 0, 1, 1, 2, 0);
        add(0, 4, 0, 0, 1, 2, 3, 0);
        add(0, 4, 0, 0, 1, 3, 4, 0);
        add(0, 4, 0, 0, 0, 4, 4, 0);
        add(0, 4, 0, 0, 0, 4, 0, 1);
        add(0, 4, 0, 0, 0, 4, 0, 1);
        add(1, 20, 0, 0, 0, 4, 0, 1);
        add(1, 20, 0, 0, 0, 0, 0, 0);
        add(0, 20, 0, 0, 1, 0, 1, 0);
        add(1, 20, 0, 0, 1, 1, 2, 0);
        add(0, 20, 0, 0, 1, 2, 3, 0);
        add(0, 20, 0, 0, 1, 3, 4, 0);
        add(0, 20, 0, 0, 1, 4, 5, 0);
        add(0, 20, 1, 3, 1, 5, 20, 0);
        add(0, 20, 0, 0, 0, 20, 20, 0);
        add(0, 20, 0, 0, 0, 20, 0, 1);
        for (int r = 0; r < 2; r++) begin
            add(1, 0, 0, 0, 0, (r == 0) ? 20 : 0, 0, 1);
            add(0, 0, 0, 0, 0, 0, 0, 0);
            add(0, 0, 0, 0, 0, 0, 0, 0);
            add(0, 0, 0, 0, 0, 0, 0, 1);
        end
        foreach (tv[i]) begin
            start = tv[i].st; end_pc = PC_W'(tv[i].endp);
            branch_en = tv[i].br; lut_index = 5'(tv[i].idx);
            #1;
            chk($sformatf("tv%0d_valid", i), {31'b0, instr_valid}, tv[i].ev);
            chk($sformatf("tv%0d_pc", i), {22'b0, pc}, tv[i].epc);
            chk($sformatf("tv%0d_addr", i), {22'b0, imem_addr}, tv[i].eaddr);
            chk($sformatf("tv%0d_done", i), {31'b0, done}, tv[i].edone);
            tick();
        end
        start = 1'b0; branch_en = 1'b0;

        // Reset in the middle of a run.
        end_pc = 10'd30; start = 1'b1;
        tick();
        start = 1'b0;
        begin
            bit found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                if (m_phase == P_RUN && m_pc == 7) found = 1'b1;
                else tick();
            end
            chk("reach_pc7", {31'b0, found}, 1);
        end
        #1;
        chk("pre_rst_pc", {22'b0, pc}, 7);
        chk("pre_rst_valid", {31'b0, instr_valid}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_pc", {22'b0, pc}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_valid", {31'b0, instr_valid}, 0);
        chk("midrst_addr", {22'b0, imem_addr}, 0);
        tick();
        check_model();

`ifdef FETCH_PERF_EN
        // Ten issued instructions, three of them taken branches.
        end_pc = 10'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && m_phase != P_HALT; c++) begin
            branch_en = (m_phase == P_RUN) && (m_pc == 2 || m_pc == 5 || m_pc == 8);
            lut_index = (m_pc == 2) ? 5'd10 : (m_pc == 5) ? 5'd11 : 5'd12;
            #1;
            check_model();
            tick();
        end
        branch_en = 1'b0;
        chk("perf_halted", {31'b0, done}, 1);
        chk("perf_icnt", {16'b0, instr_count}, 10);
        chk("perf_tcnt", {16'b0, taken_count}, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("perf_clr_i", {16'b0, instr_count}, 0);
        chk("perf_clr_t", {16'b0, taken_count}, 0);
`endif

        // Randomized run against the reference model.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 7) == 0);
            branch_en = ($urandom_range(0, 3) == 0);
            lut_index = 5'($urandom);
            lut_wr_en = ($urandom_range(0, 9) == 0);
            lut_wr_addr = ($urandom_range(0, 1) == 0) ? lut_index : 5'($urandom);
            lut_wr_data = ($urandom_range(0, 9) == 0) ? 10'd1023 : PC_W'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) end_pc = PC_W'($urandom_range(0, 40));
            #1;
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
